grp_buffer_scheduler: RTL
=========================

GRP_BUFFER_SCHEDULER -- requirements
Module: grp_buffer_scheduler

Interface
REQ-001 SHALL have parameter AW, default 10, meaning the group buffer address width.
REQ-002 SHALL have parameter DW, default 12, meaning the group buffer data width.
REQ-003 SHALL have parameter CW, default 8, meaning the underrun counter width.
REQ-004 SHALL have port clk  in  1  single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port wr_en  in  1  writer word strobe.
REQ-007 SHALL have port wr_addr  in  AW  writer word address.
REQ-008 SHALL have port wr_data  in  DW  writer word.
REQ-009 SHALL have port wr_done  in  1  one-cycle pulse: the current group is fully written.
REQ-010 SHALL have port wr_ready  out  1  the write bank accepts words.
REQ-011 SHALL have port wr_drop  out  1  one-cycle pulse: a word was rejected.
REQ-012 SHALL have port rd_en  in  1  reader word request.
REQ-013 SHALL have port rd_addr  in  AW  reader word address.
REQ-014 SHALL have port rd_swap  in  1  one-cycle pulse from the frame former at a group boundary.
REQ-015 SHALL have port rd_data  out  DW  word returned to the reader.
REQ-016 SHALL have port bank_sel  out  1  bank being read (0 = m0, 1 = m1); the write bank is ~bank_sel.
REQ-017 SHALL have ports m0_re, m0_we, m1_re, m1_we  out  1  per-bank read and write enables.
REQ-018 SHALL have ports m_wraddr  out  AW, m_data  out  DW, m_rdaddr  out  AW, shared by both banks.
REQ-019 SHALL have ports m0_q, m1_q  in  DW  bank outputs, each with 1-cycle registered read latency.
REQ-020 SHALL have port underrun  out  1  one-cycle pulse: a swap was refused.
REQ-021 SHALL have port underrun_cnt  out  CW  saturating count of underruns.

Function
REQ-022 SHALL drive m_wraddr, m_data and m_rdaddr combinationally from wr_addr, wr_data and rd_addr.
REQ-023 SHALL drive the read-bank re = rd_en, the other bank re = 0, write-bank we = wr_en & wr_ready, and the read-bank we = 0, all combinationally.
REQ-024 SHALL implement a two-state FSM, FILL (wr_ready=1) and HOLD (wr_ready=0).
REQ-025 SHALL move FILL -> HOLD on wr_done without rd_swap.
REQ-026 SHALL, on rd_swap in HOLD, toggle bank_sel on the next edge, enter FILL, and set the data-valid flag.
REQ-027 SHALL, on rd_swap in FILL without wr_done (underrun), leave bank_sel unchanged, pulse underrun one cycle later, and increment underrun_cnt, saturating at 2^CW-1.
REQ-028 SHALL, on wr_done and rd_swap together in FILL, toggle bank_sel, stay in FILL, set the data-valid flag, and raise no underrun.
REQ-029 SHALL ignore wr_done in HOLD, and SHALL ignore wr_done in FILL if wr_en coincides (the word is written, then the state changes).
REQ-030 SHALL block wr_en while wr_ready=0 (both we=0) and pulse wr_drop on the next cycle.
REQ-031 SHALL register bank_sel into bank_sel_d each cycle and drive rd_data = bank_sel_d ? m1_q : m0_q, so a read issued in the swap cycle returns pre-swap bank data.
REQ-032 SHALL apply rd_en in the rd_swap cycle to the pre-swap bank.
REQ-033 SHALL force rd_data to zero until the first successful swap after reset (data-valid flag 0).
REQ-034 SHALL give rd_data a latency of exactly 1 cycle from rd_en/rd_addr.

Reset
REQ-035 SHALL, on reset=0 at a clock edge, set state=FILL, bank_sel=0, bank_sel_d=0, data-valid=0, underrun=0, underrun_cnt=0, and wr_drop=0; wr_ready then reads 1.
REQ-036 SHALL, on reset mid-group, discard the partial group, and SHALL keep all enables 0 while reset=0.

Structure
REQ-037 SHALL place AW, DW, CW defaults and the FILL/HOLD state encoding in the shared package dtfm_pkg.
REQ-038 SHALL implement the saturating counter as sub-module underrun_counter (inc, clr, cnt); all other logic SHALL be inline.

Verification
REQ-039 SHALL cover: reset, write 1024 words to m1, wr_done, rd_swap -> bank_sel=1, m0_we asserted on the next write, rd_data of address 5 = value written.
REQ-040 SHALL cover: rd_swap in FILL -> bank_sel unchanged, underrun pulse 1 cycle later, underrun_cnt=1; 300 such swaps -> underrun_cnt=255.
REQ-041 SHALL cover: wr_done and rd_swap in the same cycle -> bank_sel toggles, state FILL, underrun stays 0.
REQ-042 SHALL cover: wr_en in HOLD -> m0_we=m1_we=0, wr_drop pulse, read data unchanged.
REQ-043 SHALL cover: rd_en addr 7 in the swap cycle -> rd_data next cycle = old bank word 7; before the first swap rd_data=0.
REQ-044 SHALL cover: reset=0 asserted in HOLD with underrun_cnt=3 -> next cycle state FILL, bank_sel=0, underrun_cnt=0, rd_data=0.

Source files
------------

// File: rtl/dtfm_pkg.sv
// rtl/dtfm_pkg.sv - shared defaults and FSM encoding for the group buffer scheduler
// Purpose : default widths and FILL/HOLD state encoding used across the slice.
// Ports   : none (package).
package dtfm_pkg;

  localparam int AW_DEF = 10;  // group buffer address width
  localparam int DW_DEF = 12;  // group buffer data width
  localparam int CW_DEF = 8;   // underrun counter width

  // FILL: write bank open to the writer. HOLD: full group waiting for a swap.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/underrun_counter.sv
// rtl/underrun_counter.sv - saturating event counter
// Purpose : counts inc pulses, holds at all-ones, synchronous clear.
// Ports   : clk - clock
//           clr - synchronous clear (priority over inc)
//           inc - count one event
//           cnt - current count
module underrun_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {CW{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/grp_buffer_scheduler.sv
// rtl/grp_buffer_scheduler.sv - ping-pong group buffer bank scheduler
// Purpose : steers a writer and a reader onto two single-port-per-direction
//           banks; the reader owns bank_sel, the writer owns ~bank_sel, and
//           the banks swap on rd_swap once the writer has finished a group.
// Ports   : clk, reset (sync, active-low)
//           wr_en/wr_addr/wr_data/wr_done in, wr_ready/wr_drop out - writer side
//           rd_en/rd_addr/rd_swap in, rd_data out                  - reader side
//           bank_sel, m0_re/m0_we/m1_re/m1_we, m_wraddr/m_data/m_rdaddr out,
//           m0_q/m1_q in                                           - bank side
//           underrun, underrun_cnt out                             - refused swaps
module grp_buffer_scheduler
  import dtfm_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_done,
  output logic          wr_ready,
  output logic          wr_drop,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_swap,
  output logic [DW-1:0] rd_data,
  output logic          bank_sel,
  output logic          m0_re,
  output logic          m0_we,
  output logic          m1_re,
  output logic          m1_we,
  output logic [AW-1:0] m_wraddr,
  output logic [DW-1:0] m_data,
  output logic [AW-1:0] m_rdaddr,
  input  logic [DW-1:0] m0_q,
  input  logic [DW-1:0] m1_q,
  output logic          underrun,
  output logic [CW-1:0] underrun_cnt
);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_bank_sel;
  logic   w_bank_sel_nxt;
  logic   r_bank_sel_d;
  logic   r_valid;
  logic   w_valid_nxt;
  logic   r_underrun;
  logic   w_underrun_ev;
  logic   r_wr_drop;
  logic   w_done_eff;
  logic   w_wr_ok;

  // A word landing in the same cycle as wr_done defers the group close.
  assign w_done_eff = wr_done & ~wr_en;
  assign wr_ready   = (r_state == ST_FILL);
  // Gating with reset keeps every bank enable low while reset is held.
  assign w_wr_ok    = reset & wr_en & wr_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_bank_sel_nxt = r_bank_sel;
    w_valid_nxt    = r_valid;
    w_underrun_ev  = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (rd_swap && w_done_eff) begin
          // Group closes exactly as the reader asks: swap and keep filling.
          w_bank_sel_nxt = ~r_bank_sel;
          w_valid_nxt    = 1'b1;
        end else if (w_done_eff) begin
          w_state_nxt = ST_HOLD;
        end else if (rd_swap) begin
          w_underrun_ev = 1'b1;
        end
      end
      ST_HOLD: begin
        if (rd_swap) begin
          w_bank_sel_nxt = ~r_bank_sel;
          w_state_nxt    = ST_FILL;
          w_valid_nxt    = 1'b1;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_FILL;
      r_bank_sel   <= 1'b0;
      r_bank_sel_d <= 1'b0;
      r_valid      <= 1'b0;
      r_underrun   <= 1'b0;
      r_wr_drop    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bank_sel   <= w_bank_sel_nxt;
      r_bank_sel_d <= r_bank_sel;
      r_valid      <= w_valid_nxt;
      r_underrun   <= w_underrun_ev;
      r_wr_drop    <= wr_en & ~wr_ready;
    end
  end

  underrun_counter #(.CW(CW)) u_underrun_counter (
    .clk (clk),
    .clr (~reset),
    .inc (w_underrun_ev),
    .cnt (underrun_cnt)
  );

  assign bank_sel = r_bank_sel;
  assign underrun = r_underrun;
  assign wr_drop  = r_wr_drop;

  assign m_wraddr = wr_addr;
  assign m_data   = wr_data;
  assign m_rdaddr = rd_addr;

  assign m0_re = reset & rd_en & ~r_bank_sel;
  assign m1_re = reset & rd_en &  r_bank_sel;
  assign m0_we = w_wr_ok &  r_bank_sel;
  assign m1_we = w_wr_ok & ~r_bank_sel;

  // bank_sel_d tracks which bank produced this cycle's q, so a read issued
  // in the swap cycle still comes back from the pre-swap bank.
  assign rd_data = r_valid ? (r_bank_sel_d ? m1_q : m0_q) : '0;

endmodule
